// File: rtl/multi_cycle_control_if.sv
// Memory handshake between the multi-cycle controller and its memory port.
// Handshake: the controller holds mem_req_o/mem_we_o/IorD_o steady until the memory raises mem_ready_i, which completes the access in that same cycle.
interface multi_cycle_control_if;
  logic mem_req_o;
  logic mem_we_o;
  logic IorD_o;
  logic mem_ready_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output IorD_o,
    input  mem_ready_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  IorD_o,
    output mem_ready_i
  );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle RV-subset controller: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencer
// driving datapath strobes, with a retired-instruction counter.
module multi_cycle_control #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [6:0]           opcode_i,
  input  logic                 zero_i,
  multi_cycle_control_if.master mem,
  output logic                 IRWrite_o,
  output logic                 PCWrite_o,
  output logic                 RegWrite_o,
  output logic                 MemtoReg_o,
  output logic                 ALUSrc_o,
  output logic                 PCSrc_o,
  output logic [1:0]           ALUOp_o,
  output logic                 busy_o,
  output logic                 illegal_o,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [2:0]           state;
  logic [2:0]           state_next;
  logic [2:0]           after_retire;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;

  logic is_r, is_i, is_lw, is_sw, is_beq, is_legal;

  assign is_r     = (opcode_i == OP_R);
  assign is_i     = (opcode_i == OP_I);
  assign is_lw    = (opcode_i == OP_LW);
  assign is_sw    = (opcode_i == OP_SW);
  assign is_beq   = (opcode_i == OP_BEQ);
  assign is_legal = is_r | is_i | is_lw | is_sw | is_beq;

  // Shared exit for every retire point and for an illegal decode.
  assign after_retire = start_i ? S_FETCH : S_IDLE;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)       instret <= '0;
    else if (retire) instret <= instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_next = state;
    retire     = 1'b0;
    case (state)
      S_IDLE:   state_next = start_i ? S_FETCH : S_IDLE;
      S_FETCH:  if (mem.mem_ready_i) state_next = S_DECODE;
      S_DECODE: state_next = is_legal ? S_EXEC : after_retire;
      S_EXEC: begin
        if (is_r || is_i)        state_next = S_WB;
        else if (is_lw || is_sw) state_next = S_MEM;
        else if (is_beq) begin
          retire     = 1'b1;
          state_next = after_retire;
        end else                 state_next = after_retire;
      end
      S_MEM: begin
        if (mem.mem_ready_i) begin
          if (is_sw) begin
            retire     = 1'b1;
            state_next = after_retire;
          end else     state_next = S_WB;
        end
      end
      S_WB: begin
        retire     = 1'b1;
        state_next = after_retire;
      end
      default:  state_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req_o = 1'b0;
    mem.mem_we_o  = 1'b0;
    mem.IorD_o    = 1'b0;
    IRWrite_o     = 1'b0;
    PCWrite_o     = 1'b0;
    RegWrite_o    = 1'b0;
    MemtoReg_o    = 1'b0;
    ALUSrc_o      = 1'b0;
    PCSrc_o       = 1'b0;
    ALUOp_o       = 2'b00;
    illegal_o     = 1'b0;
    case (state)
      S_FETCH: begin
        mem.mem_req_o = 1'b1;
        IRWrite_o     = mem.mem_ready_i;
        PCWrite_o     = mem.mem_ready_i;
      end
      S_DECODE: illegal_o = ~is_legal;
      S_EXEC: begin
        if (is_r) begin
          ALUOp_o = 2'b10;
        end else if (is_i) begin
          ALUSrc_o = 1'b1;
          ALUOp_o  = 2'b11;
        end else if (is_lw || is_sw) begin
          ALUSrc_o = 1'b1;
        end else if (is_beq) begin
          ALUOp_o   = 2'b01;
          PCSrc_o   = 1'b1;
          PCWrite_o = zero_i;
        end
      end
      S_MEM: begin
        mem.mem_req_o = 1'b1;
        mem.IorD_o    = 1'b1;
        mem.mem_we_o  = is_sw;
      end
      S_WB: begin
        RegWrite_o = 1'b1;
        MemtoReg_o = is_lw;
      end
      default: ;
    endcase
  end

  assign busy_o    = (state != S_IDLE);
  assign state_o   = state;
  assign instret_o = instret;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: the driver builds each instruction's cycle
// timeline from opcode semantics; a negedge monitor compares every cycle.
module tb_multi_cycle_control;

  localparam int W  = 20;
  localparam int IW = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [6:0]    opcode = 7'd0;
  logic          zero = 1'b0;
  logic          irwrite, pcwrite, regwrite, memtoreg, alusrc, pcsrc;
  logic [1:0]    aluop;
  logic          busy, illegal;
  logic [2:0]    state;
  logic [IW-1:0] instret;

  multi_cycle_control_if mem_bus ();

  multi_cycle_control #(.INSTRET_W(IW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .opcode_i   (opcode),
    .zero_i     (zero),
    .mem        (mem_bus),
    .IRWrite_o  (irwrite),
    .PCWrite_o  (pcwrite),
    .RegWrite_o (regwrite),
    .MemtoReg_o (memtoreg),
    .ALUSrc_o   (alusrc),
    .PCSrc_o    (pcsrc),
    .ALUOp_o    (aluop),
    .busy_o     (busy),
    .illegal_o  (illegal),
    .state_o    (state),
    .instret_o  (instret)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int m_instret = 0;
  bit in_idle = 1'b1;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd7();
    return 7'($urandom);
  endfunction

  // Expected output vector for one cycle; instret comes from the model counter.
  function automatic logic [W-1:0] mk(input logic [2:0] st, input logic ill, req, we, iord,
                                      irw, pcw, rw, m2r, asrc, psrc, input logic [1:0] aop);
    logic [IW-1:0] ir;
    ir = IW'(m_instret);
    return {st, (st != S_IDLE), ill, req, we, iord, irw, pcw, rw, m2r, asrc, psrc, aop, ir};
  endfunction

  // Driver: one call per clock cycle
  task automatic cyc(input logic r, s, input logic [6:0] op, input logic z, rdy,
                     input logic push, input logic [W-1:0] v);
    @(posedge clk);
    #1;
    rst                 = r;
    start               = s;
    opcode              = op;
    zero                = z;
    mem_bus.mem_ready_i = rdy;
    if (push) exp_q.push_back(v);
  endtask

  task automatic retire(input logic s_end);
    m_instret = (m_instret + 1) % (1 << IW);
    in_idle   = !s_end;
  endtask

  task automatic idle_start(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b0, rnd7(), rb(), rb(), 1'b1, mk(S_IDLE, 0,0,0,0,0,0,0,0,0,0, 2'b00));
    cyc(1'b0, 1'b1, rnd7(), rb(), rb(), 1'b1, mk(S_IDLE, 0,0,0,0,0,0,0,0,0,0, 2'b00));
    in_idle = 1'b0;
  endtask

  // One instruction from FETCH; rst_at: 0 none, 1 reset during EXEC, 2 during first MEM wait.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic z, input logic s_end, input int rst_at);
    logic is_r, is_i, is_lw, is_sw, is_beq, legal;
    logic [W-1:0] v;
    is_r   = (op == OP_R);
    is_i   = (op == OP_I);
    is_lw  = (op == OP_LW);
    is_sw  = (op == OP_SW);
    is_beq = (op == OP_BEQ);
    legal  = is_r | is_i | is_lw | is_sw | is_beq;

    for (int i = 0; i < fw; i++)
      cyc(1'b0, rb(), rnd7(), rb(), 1'b0, 1'b1, mk(S_FETCH, 0,1,0,0,0,0,0,0,0,0, 2'b00));
    cyc(1'b0, rb(), rnd7(), rb(), 1'b1, 1'b1, mk(S_FETCH, 0,1,0,0,1,1,0,0,0,0, 2'b00));

    if (!legal) begin
      cyc(1'b0, s_end, op, rb(), rb(), 1'b1, mk(S_DECODE, 1,0,0,0,0,0,0,0,0,0, 2'b00));
      in_idle = !s_end;
      return;
    end
    cyc(1'b0, rb(), op, rb(), rb(), 1'b1, mk(S_DECODE, 0,0,0,0,0,0,0,0,0,0, 2'b00));

    if (is_r)        v = mk(S_EXEC, 0,0,0,0,0,0,0,0,0,0, 2'b10);
    else if (is_i)   v = mk(S_EXEC, 0,0,0,0,0,0,0,0,1,0, 2'b11);
    else if (is_beq) v = mk(S_EXEC, 0,0,0,0,0,z,0,0,0,1, 2'b01);
    else             v = mk(S_EXEC, 0,0,0,0,0,0,0,0,1,0, 2'b00);
    cyc(rst_at == 1, is_beq ? s_end : rb(), op, z, rb(), 1'b1, v);
    if (rst_at == 1) begin
      m_instret = 0;
      in_idle   = 1'b1;
      return;
    end
    if (is_beq) begin
      retire(s_end);
      return;
    end

    if (is_lw || is_sw) begin
      v = mk(S_MEM, 0,1,is_sw,1,0,0,0,0,0,0, 2'b00);
      for (int i = 0; i < mw; i++) begin
        cyc(rst_at == 2 && i == 0, rb(), op, rb(), 1'b0, 1'b1, v);
        if (rst_at == 2 && i == 0) begin
          m_instret = 0;
          in_idle   = 1'b1;
          return;
        end
      end
      cyc(1'b0, is_sw ? s_end : rb(), op, rb(), 1'b1, 1'b1, v);
      if (is_sw) begin
        retire(s_end);
        return;
      end
    end

    cyc(1'b0, s_end, op, rb(), rb(), 1'b1, mk(S_WB, 0,0,0,0,0,0,1,is_lw,0,0, 2'b00));
    retire(s_end);
  endtask

  // Monitor: pops one expectation per cycle the driver issued
  initial begin
    logic [W-1:0] got, exp;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {state, busy, illegal, mem_bus.mem_req_o, mem_bus.mem_we_o, mem_bus.IorD_o,
               irwrite, pcwrite, regwrite, memtoreg, alusrc, pcsrc, aluop, instret};
        n_tests++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL cycle_outputs t=%0t got=%05h exp=%05h (state got %0d exp %0d, instret got %0d exp %0d)",
                   $time, got, exp, got[W-1 -: 3], exp[W-1 -: 3], got[IW-1:0], exp[IW-1:0]);
        end
      end
    end
  end

  // Stimulus
  initial begin
    logic [6:0] op;
    mem_bus.mem_ready_i = 1'b0;
    cyc(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, '0);
    idle_start(2);

    run_instr(OP_R,   0, 0, 1'b0, 1'b1, 0);
    run_instr(OP_LW,  2, 2, 1'b0, 1'b1, 0);
    run_instr(OP_BEQ, 0, 0, 1'b1, 1'b1, 0);
    run_instr(OP_BEQ, 0, 0, 1'b0, 1'b1, 0);
    run_instr(7'h7f,  0, 0, 1'b0, 1'b1, 0);
    run_instr(OP_I,   1, 0, 1'b1, 1'b1, 0);
    run_instr(OP_SW,  0, 1, 1'b0, 1'b0, 0);
    idle_start(1);
    run_instr(OP_LW,  0, 0, 1'b0, 1'b1, 1);
    idle_start(0);
    run_instr(OP_SW,  1, 3, 1'b0, 1'b1, 2);
    idle_start(1);
    run_instr(7'h00,  0, 0, 1'b0, 1'b0, 0);

    for (int k = 0; k < 60; k++) begin
      if (in_idle) idle_start($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0:       op = OP_R;
        1:       op = OP_I;
        2:       op = OP_LW;
        3:       op = OP_SW;
        4:       op = OP_BEQ;
        default: op = rnd7();
      endcase
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rb(),
                ($urandom_range(0, 3) != 0), 0);
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 The block SHALL have parameter INSTRET_W, default 32, giving the width of the retired-instruction counter.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start_i, input, 1 bit: run enable, sampled in IDLE and at each retire point.
REQ-005 The block SHALL have port opcode_i, input, 7 bits: IR[6:0], valid from DECODE onward.
REQ-006 The block SHALL have port zero_i, input, 1 bit: ALU zero flag, used in EXEC for BEQ.
REQ-007 The block SHALL have port mem_ready_i, input, 1 bit: memory completes the current access this cycle.
REQ-008 The block SHALL have port mem_req_o, output, 1 bit: memory access request.
REQ-009 The block SHALL have port mem_we_o, output, 1 bit: the access is a write.
REQ-010 The block SHALL have port IorD_o, output, 1 bit: address select (0 = PC, 1 = ALU result).
REQ-011 The block SHALL have ports IRWrite_o, PCWrite_o, RegWrite_o, MemtoReg_o, ALUSrc_o, PCSrc_o, outputs, 1 bit each: datapath strobes and selects.
REQ-012 The block SHALL have port ALUOp_o, output, 2 bits: 00 add, 01 sub, 10 R-type funct, 11 I-type funct.
REQ-013 The block SHALL have ports busy_o (1 bit), illegal_o (1 bit), state_o (3 bits) and instret_o (INSTRET_W bits), all outputs.

Function
REQ-014 States SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5; codes 6 and 7 SHALL go to IDLE on the next edge.
REQ-015 In every state, all strobes and selects not listed for that state SHALL be 0; ALUOp_o SHALL be 00 unless listed.
REQ-016 IDLE: next state FETCH if start_i=1, else IDLE.
REQ-017 FETCH: mem_req_o=1, IorD_o=0; hold FETCH while mem_ready_i=0.
REQ-018 FETCH with mem_ready_i=1: IRWrite_o=1, PCWrite_o=1, PCSrc_o=0 in the same cycle; next state DECODE.
REQ-019 DECODE: one cycle, no strobes asserted.
REQ-020 DECODE, legal opcode (0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ): next state EXEC.
REQ-021 DECODE, any other opcode: illegal_o=1 for that cycle only; the instruction is not counted; the retire rule (REQ-027) applies.
REQ-022 EXEC, R-type: ALUSrc_o=0, ALUOp_o=10; next state WB.
REQ-023 EXEC, I-ALU: ALUSrc_o=1, ALUOp_o=11; next state WB.
REQ-024 EXEC, LW or SW: ALUSrc_o=1, ALUOp_o=00; next state MEM.
REQ-025 EXEC, BEQ: ALUSrc_o=0, ALUOp_o=01, PCSrc_o=1, PCWrite_o=zero_i; BEQ retires in this cycle.
REQ-026 MEM: mem_req_o=1, IorD_o=1, mem_we_o=1 for SW; hold while mem_ready_i=0; on ready, SW retires and LW goes to WB.
REQ-027 WB: RegWrite_o=1, MemtoReg_o=1 for LW only; retires. At every retire point (or illegal DECODE), next state SHALL be FETCH if start_i=1, else IDLE.
REQ-028 instret_o SHALL increment by 1 on each retire edge and wrap from 2^INSTRET_W-1 to 0.
REQ-029 mem_ready_i SHALL be ignored outside FETCH and MEM; mem_req_o, mem_we_o and IorD_o SHALL remain stable while waiting.
REQ-030 Outputs SHALL be Moore functions of state and opcode_i, except PCWrite_o, IRWrite_o and next-state logic, which also use zero_i and mem_ready_i.
REQ-031 busy_o SHALL be 1 in every state except IDLE; state_o SHALL show the current state code.
REQ-032 Latency (zero-wait memory): R/I = 4 cycles, BEQ = 3, LW = 5, SW = 4, illegal = 2.

Reset
REQ-033 When rst_i=1 at an edge, the next state SHALL be IDLE and instret_o SHALL become 0, overriding all other conditions, including a reset in the middle of an instruction or a memory wait.
REQ-034 After reset, all strobes, ALUOp_o, illegal_o and busy_o SHALL be 0, and state_o SHALL be 0.

Verification
REQ-035 Reset, start_i=1, zero-wait memory, R-type: FETCH, DECODE, EXEC (ALUOp=10), WB (RegWrite=1), FETCH; instret_o=1 after 4 cycles.
REQ-036 LW with mem_ready_i low for 2 cycles in both FETCH and MEM: 9 cycles total; MemtoReg_o=1 in WB; IRWrite_o pulses exactly once.
REQ-037 BEQ with zero_i=1, then BEQ with zero_i=0: PCWrite_o=1 in EXEC for the first, 0 for the second; both counted.
REQ-038 Opcode 1111111: illegal_o is a 1-cycle pulse in DECODE; next state FETCH; instret_o unchanged.
REQ-039 start_i dropped during MEM of SW: mem_we_o=1, retire, IDLE, busy_o=0; rst_i in EXEC: IDLE next cycle, instret_o=0.
REQ-040 INSTRET_W=4: 16 retired instructions bring instret_o back to 0.
